issue_queue_n: RTL and testbench

//  In-order circular issue queue between decode and execute. It generalises the

---
 rtl/issue_queue_n_if.sv | 31 +++
 rtl/issue_queue_n.sv | 110 +++++++++++
 tb/tb_issue_queue_n.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_n_if.sv
// Issue queue port bundle: enqueue group, peek/pop window, flush, status.
// master = decode/execute side, slave = queue.
interface issue_queue_n_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int ISS_W  = 2
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(ISS_W + 1);

    logic                      flush;
    logic [ENQ_W-1:0]          enq_valid;
    logic [ENQ_W*DATA_W-1:0]   enq_data;
    logic                      enq_ready;
    logic [ISS_W-1:0]          iss_valid;
    logic [ISS_W*DATA_W-1:0]   iss_data;
    logic [IW-1:0]             deq_cnt;
    logic [CW-1:0]             count;
    logic                      overflow;

    modport master (
        output flush, enq_valid, enq_data, deq_cnt,
        input  enq_ready, iss_valid, iss_data, count, overflow
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_cnt,
        output enq_ready, iss_valid, iss_data, count, overflow
    );
endinterface

// File: rtl/issue_queue_n.sv
// In-order circular issue queue: ENQ_W compacting enqueue lanes, ISS_W-wide
// peek window, consumer-chosen pop count, flush on redirect.
// Ports: clk, resetn (async, active-low), bus (issue_queue_n_if.slave).
module issue_queue_n #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int ISS_W  = 2
) (
    input  logic           clk,
    input  logic           resetn,
    issue_queue_n_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;

    logic              w_ready;
    logic [CW-1:0]     w_n_enq;
    logic [CW-1:0]     w_deq;
    logic [CW-1:0]     w_eff;
    logic [DEPTH-1:0]  w_wr_en;
    logic [DATA_W-1:0] w_wr_data [DEPTH];
    logic [ISS_W-1:0]  w_iss_valid;
    logic [ISS_W*DATA_W-1:0] w_iss_data;

    // Registered count only: slots freed by this cycle's pop are not reused
    // until next cycle, which keeps ready independent of deq_cnt.
    assign w_ready = (CW'(DEPTH) - r_count) >= CW'(ENQ_W);

    // Valid lanes pack into consecutive slots from tail, lane 0 first.
    always_comb begin
        w_n_enq = '0;
        w_wr_en = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_wr_data[s] = '0;
        end
        for (int l = 0; l < ENQ_W; l++) begin
            if (bus.enq_valid[l]) begin
                w_wr_en[r_tail + PW'(w_n_enq)] = 1'b1;
                w_wr_data[r_tail + PW'(w_n_enq)] =
                    bus.enq_data[l*DATA_W +: DATA_W];
                w_n_enq = w_n_enq + CW'(1);
            end
        end
    end

    // Silent clamp of the pop request to occupancy and window width.
    always_comb begin
        w_deq = CW'(bus.deq_cnt);
        if (w_deq > CW'(ISS_W)) begin
            w_deq = CW'(ISS_W);
        end
        w_eff = (w_deq < r_count) ? w_deq : r_count;
    end

    // Stale slots beyond count are masked to zero.
    always_comb begin
        w_iss_valid = '0;
        w_iss_data  = '0;
        for (int i = 0; i < ISS_W; i++) begin
            w_iss_valid[i] = CW'(i) < r_count;
            if (w_iss_valid[i]) begin
                w_iss_data[i*DATA_W +: DATA_W] = r_mem[r_head + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                r_mem[s] <= '0;
            end
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf  <= (|bus.enq_valid) & ~w_ready;
            r_head <= r_head + PW'(w_eff);
            if (w_ready) begin
                r_tail  <= r_tail + PW'(w_n_enq);
                r_count <= r_count + w_n_enq - w_eff;
                for (int s = 0; s < DEPTH; s++) begin
                    if (w_wr_en[s]) begin
                        r_mem[s] <= w_wr_data[s];
                    end
                end
            end else begin
                r_count <= r_count - w_eff;
            end
        end
    end

    assign bus.enq_ready = w_ready;
    assign bus.iss_valid = w_iss_valid;
    assign bus.iss_data  = w_iss_data;
    assign bus.count     = r_count;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_issue_queue_n.sv
// Directed vector table plus FIFO-model random run for issue_queue_n.
// Checks count, overflow, enq_ready and the peek window after each edge.
module tb_issue_queue_n;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    issue_queue_n_if #(.DATA_W(64), .DEPTH(8), .ENQ_W(2), .ISS_W(2)) bus ();

    issue_queue_n #(.DATA_W(64), .DEPTH(8), .ENQ_W(2), .ISS_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        fl;
        logic [1:0]  v;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  dq;
        logic [3:0]  cnt;
        logic        ovf;
        logic        rdy;
        logic [1:0]  iv;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;
    logic [63:0] q[$];

    function automatic vec_t mk(string nm, logic fl, logic [1:0] v,
                                logic [63:0] d0, logic [63:0] d1,
                                logic [1:0] dq, logic [3:0] cnt,
                                logic ovf, logic rdy, logic [1:0] iv,
                                logic [63:0] e0, logic [63:0] e1);
        vec_t t;
        t.nm = nm; t.fl = fl; t.v = v; t.d0 = d0; t.d1 = d1; t.dq = dq;
        t.cnt = cnt; t.ovf = ovf; t.rdy = rdy; t.iv = iv;
        t.e0 = e0; t.e1 = e1;
        return t;
    endfunction

    function automatic logic [135:0] pack(logic [3:0] cnt, logic ovf,
                                          logic rdy, logic [1:0] iv,
                                          logic [63:0] e1, logic [63:0] e0);
        return {cnt, ovf, rdy, iv, e1, e0};
    endfunction

    function automatic logic [135:0] actual();
        return {bus.count, bus.overflow, bus.enq_ready, bus.iss_valid,
                bus.iss_data[127:64], bus.iss_data[63:0]};
    endfunction

    task automatic chk(string nm, logic [135:0] exp);
        logic [135:0] act;
        act = actual();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (cnt|ovf|rdy|iv|d1|d0)",
                     nm, act, exp);
        end
    endtask

    task automatic drive(logic fl, logic [1:0] v, logic [63:0] d0,
                         logic [63:0] d1, logic [1:0] dq);
        bus.flush     = fl;
        bus.enq_valid = v;
        bus.enq_data  = {d1, d0};
        bus.deq_cnt   = dq;
    endtask

    initial begin
        drive(1'b0, 2'b11, 64'h5, 64'h6, 2'd0);

        // reset held with enqueue requested
        tbl.push_back(mk("t2_lane1", 0, 2'b10, 0, 64'hA, 0, 1, 0, 1, 2'b01, 64'hA, 0));
        tbl.push_back(mk("t2_both", 0, 2'b11, 64'hB, 64'hC, 0, 3, 0, 1, 2'b11, 64'hA, 64'hB));
        tbl.push_back(mk("deq2", 0, 2'b00, 0, 0, 2, 1, 0, 1, 2'b01, 64'hC, 0));
        tbl.push_back(mk("fill3", 0, 2'b11, 64'hD, 64'hE, 0, 3, 0, 1, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("fill5", 0, 2'b11, 64'hF, 64'h10, 0, 5, 0, 1, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("fill7", 0, 2'b11, 64'h11, 64'h12, 0, 7, 0, 0, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("ovf", 0, 2'b11, 64'h13, 64'h14, 0, 7, 1, 0, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("ovf_pulse", 0, 2'b00, 0, 0, 0, 7, 0, 0, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("ovf_again", 0, 2'b01, 64'h15, 0, 0, 7, 1, 0, 2'b11, 64'hC, 64'hD));
        tbl.push_back(mk("flush_ovf", 1, 2'b11, 64'h16, 64'h17, 2, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk("w_1_2", 0, 2'b11, 64'h1, 64'h2, 0, 2, 0, 1, 2'b11, 64'h1, 64'h2));
        tbl.push_back(mk("w_3_4", 0, 2'b11, 64'h3, 64'h4, 0, 4, 0, 1, 2'b11, 64'h1, 64'h2));
        tbl.push_back(mk("w_5_6", 0, 2'b11, 64'h5, 64'h6, 0, 6, 0, 1, 2'b11, 64'h1, 64'h2));
        tbl.push_back(mk("w_7", 0, 2'b10, 0, 64'h7, 0, 7, 0, 0, 2'b11, 64'h1, 64'h2));
        tbl.push_back(mk("deq1", 0, 2'b00, 0, 0, 1, 6, 0, 1, 2'b11, 64'h2, 64'h3));
        tbl.push_back(mk("t4_enq_deq", 0, 2'b11, 64'h8, 64'h9, 2, 6, 0, 1, 2'b11, 64'h4, 64'h5));
        tbl.push_back(mk("drain_a", 0, 2'b00, 0, 0, 2, 4, 0, 1, 2'b11, 64'h6, 64'h7));
        tbl.push_back(mk("rd_wrap", 0, 2'b00, 0, 0, 2, 2, 0, 1, 2'b11, 64'h8, 64'h9));
        tbl.push_back(mk("drain_b", 0, 2'b00, 0, 0, 2, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk("t5_enq", 0, 2'b01, 64'h11, 0, 0, 1, 0, 1, 2'b01, 64'h11, 0));
        tbl.push_back(mk("t5_clamp", 0, 2'b00, 0, 0, 2, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk("t5_next", 0, 2'b01, 64'h22, 0, 0, 1, 0, 1, 2'b01, 64'h22, 0));
        tbl.push_back(mk("clamp3", 0, 2'b11, 64'h33, 64'h44, 3, 2, 0, 1, 2'b11, 64'h33, 64'h44));
        tbl.push_back(mk("t6_pre", 0, 2'b01, 64'h45, 0, 0, 3, 0, 1, 2'b11, 64'h33, 64'h44));
        tbl.push_back(mk("t6_flush", 1, 2'b11, 64'h46, 64'h47, 2, 0, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk("t6_after", 0, 2'b01, 64'h55, 0, 0, 1, 0, 1, 2'b01, 64'h55, 0));

        @(posedge clk);
        #1;
        chk("rst_hold", pack(0, 0, 1, 2'b00, 0, 0));
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 2'd0);
        @(posedge clk);
        #1;
        chk("rst_release", pack(0, 0, 1, 2'b00, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].fl, tbl[k].v, tbl[k].d0, tbl[k].d1, tbl[k].dq);
            @(posedge clk);
            #1;
            chk(tbl[k].nm, pack(tbl[k].cnt, tbl[k].ovf, tbl[k].rdy,
                                tbl[k].iv, tbl[k].e1, tbl[k].e0));
        end

        q.push_back(64'h55);
        for (int c = 0; c < 10000; c++) begin
            logic        fl;
            logic [1:0]  v;
            logic [1:0]  dq;
            logic [63:0] d0;
            logic [63:0] d1;
            logic        rdy;
            logic        ovf;
            int          eff;
            logic [1:0]  iv;
            logic [63:0] e0;
            logic [63:0] e1;
            fl = ($urandom_range(0, 63) == 0);
            v  = 2'($urandom_range(0, 3));
            dq = 2'($urandom_range(0, 3));
            d0 = {$urandom, $urandom};
            d1 = {$urandom, $urandom};
            @(negedge clk);
            drive(fl, v, d0, d1, dq);
            rdy = (8 - q.size()) >= 2;
            if (fl) begin
                q.delete();
                ovf = 1'b0;
            end else begin
                ovf = (v != 2'b00) && !rdy;
                eff = int'(dq);
                if (eff > 2) eff = 2;
                if (eff > q.size()) eff = q.size();
                for (int p = 0; p < eff; p++) void'(q.pop_front());
                if (rdy && v[0]) q.push_back(d0);
                if (rdy && v[1]) q.push_back(d1);
            end
            iv = {q.size() > 1, q.size() > 0};
            e0 = (q.size() > 0) ? q[0] : 64'h0;
            e1 = (q.size() > 1) ? q[1] : 64'h0;
            @(posedge clk);
            #1;
            chk("rand", pack(4'(q.size()), ovf, (8 - q.size()) >= 2,
                             iv, e1, e0));
        end

        @(negedge clk);
        drive(1'b0, 2'b11, 64'h66, 64'h77, 2'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_midop", pack(0, 0, 1, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        chk("rst_midop_edge", pack(0, 0, 1, 2'b00, 0, 0));
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 2'b01, 64'h88, 0, 2'd0);
        @(posedge clk);
        #1;
        chk("post_rst_enq", pack(1, 0, 1, 2'b01, 0, 64'h88));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
